rob_commit_monitor: RTL
=======================

ROB_COMMIT_MONITOR -- requirements
Module: rob_commit_monitor

Interface
REQ-001 SHALL have parameter COMMIT_W, default 2, number of ROB commit lanes (1-4).
REQ-002 SHALL have parameter TRACE_DEPTH, default 16, trace FIFO entries (power of 2, >= 4).
REQ-003 SHALL have parameter CNT_W, default 32, width of every event counter.
REQ-004 SHALL have parameter HANG_CYCLES, default 1024, no-commit cycles before hang is flagged.
REQ-005 SHALL have the port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have the port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have the port commit_valid  in  COMMIT_W  lane i retires an instruction this cycle.
REQ-008 SHALL have the ports commit_pc  in  COMMIT_W*32, commit_order  in  COMMIT_W*64, and commit_inst  in  COMMIT_W*32, per-lane rvfi pc, order and inst.
REQ-009 SHALL have the ports mispredict, rob_empty and rob_full, each  in  1, ROB status for the cycle.
REQ-010 SHALL have the port clear  in  1  synchronous flush of counters, flags and trace FIFO.
REQ-011 SHALL have the ports trace_valid  out  1, trace_ready  in  1, trace_pc  out  32, trace_order  out  64 and trace_inst  out  32, forming the trace FIFO head pop interface.
REQ-012 SHALL have the ports cnt_commit, cnt_mispred, cnt_full, cnt_empty and cnt_drop, each  out  CNT_W, event counters.
REQ-013 SHALL have the ports hang  out  1 and order_err  out  1, sticky fault flags.

Function
REQ-014 SHALL increment cnt_commit by popcount(commit_valid) each cycle.
REQ-015 SHALL increment cnt_mispred, cnt_full and cnt_empty by 1 in each cycle where mispredict, rob_full or rob_empty is high, respectively.
REQ-016 SHALL saturate every counter at 2^CNT_W-1, with no wrap.
REQ-017 SHALL write valid lanes into the trace FIFO in ascending lane order, at up to COMMIT_W writes per cycle.
REQ-018 SHALL take free space as TRACE_DEPTH minus the pre-edge occupancy, so a same-cycle pop does not free space for the same cycle's writes.
REQ-019 SHALL drop the highest-numbered lanes that do not fit and add the number dropped to cnt_drop; the FIFO contents SHALL be unchanged by a drop.
REQ-020 SHALL present the FIFO head on trace_* as first-word-fall-through, with an entry written at edge N visible after edge N.
REQ-021 SHALL pop the head on trace_valid && trace_ready; trace_* SHALL be stable while trace_valid && !trace_ready.
REQ-022 SHALL hold an expected_order register, reset to 0; each valid lane i SHALL carry order == expected_order + i.
REQ-023 SHALL set order_err on any lane-order mismatch, or on non-contiguous commit_valid (a valid lane above an invalid lane).
REQ-024 SHALL, after any commit, set expected_order to the highest valid lane's order + 1, resyncing after an error.
REQ-025 SHALL increment a watchdog idle counter when commit_valid == 0 && !rob_empty, and clear it on any commit or when rob_empty is high.
REQ-026 SHALL set hang when the idle counter reaches HANG_CYCLES; the idle counter SHALL then hold.
REQ-027 SHALL keep hang and order_err sticky until clear or reset.
REQ-028 SHALL, on clear, zero all counters, flags, expected_order and the idle counter and empty the FIFO at the next edge; clear SHALL override same-cycle commits, pops and events.

Reset
REQ-029 SHALL, on rst_n low, immediately zero all counters, hang, order_err, expected_order, the idle counter and the FIFO pointers, and drive trace_valid low.
REQ-030 SHALL, on rst_n low mid-operation, discard FIFO contents and accept commits again from the first edge after deassertion.

Verification
REQ-031 SHALL be covered by: COMMIT_W=2, commits of order 0,1 then 2,3 -> cnt_commit=4, order_err=0, FIFO pops return orders 0,1,2,3 in sequence.
REQ-032 SHALL be covered by: FIFO holding 15/16 with both lanes valid and trace_ready=1 -> lane0 stored, lane1 dropped, cnt_drop=1, occupancy=15 after the edge.
REQ-033 SHALL be covered by: commit order 5 when 4 is expected -> order_err=1 next cycle; a following commit of 6 is accepted with no new error, and the flag stays set.
REQ-034 SHALL be covered by: commit_valid=2'b10 -> order_err=1.
REQ-035 SHALL be covered by: HANG_CYCLES=8, rob_empty=0 and no commits for 8 cycles -> hang=1 after the 8th edge; with a commit at cycle 7 instead, hang=0.
REQ-036 SHALL be covered by: CNT_W=4, rob_full high for 20 cycles -> cnt_full=15; then clear=1 with a same-cycle commit -> all counters 0 and FIFO empty.

Source files
------------

// File: rtl/rob_commit_monitor.sv
// ROB commit monitor: event counters, lane-order checking, watchdog hang
// detection and a first-word-fall-through trace FIFO of retired instructions.
module rob_commit_monitor #(
  parameter int COMMIT_W    = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 32,
  parameter int HANG_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COMMIT_W-1:0]   commit_valid,
  input  logic [COMMIT_W*32-1:0] commit_pc,
  input  logic [COMMIT_W*64-1:0] commit_order,
  input  logic [COMMIT_W*32-1:0] commit_inst,
  input  logic                  mispredict,
  input  logic                  rob_empty,
  input  logic                  rob_full,
  input  logic                  clear,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [63:0]           trace_order,
  output logic [31:0]           trace_inst,
  output logic [CNT_W-1:0]      cnt_commit,
  output logic [CNT_W-1:0]      cnt_mispred,
  output logic [CNT_W-1:0]      cnt_full,
  output logic [CNT_W-1:0]      cnt_empty,
  output logic [CNT_W-1:0]      cnt_drop,
  output logic                  hang,
  output logic                  order_err
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int IW = $clog2(HANG_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(TRACE_DEPTH);
  localparam logic [IW-1:0] HANG_L  = IW'(HANG_CYCLES);

  logic [31:0] pc_mem_r    [TRACE_DEPTH];
  logic [63:0] order_mem_r [TRACE_DEPTH];
  logic [31:0] inst_mem_r  [TRACE_DEPTH];

  logic [AW:0]          wr_ptr_r, rd_ptr_r, occ_s, free_s, n_store_s;
  logic [COMMIT_W-1:0]  wr_en_s;
  logic [AW-1:0]        wr_idx_s [COMMIT_W];
  logic [2:0]           n_valid_s, n_drop_s;
  logic                 order_bad_s, gap_s, pop_s;
  logic [63:0]          last_order_s, expected_order_r;
  logic [IW-1:0]        idle_r, idle_nxt_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Free space uses pre-edge occupancy, so a same-cycle pop never makes room for this cycle's writes.
  assign occ_s       = wr_ptr_r - rd_ptr_r;
  assign free_s      = DEPTH_L - occ_s;
  assign trace_valid = (occ_s != '0);
  assign pop_s       = trace_valid && trace_ready;
  assign trace_pc    = pc_mem_r[rd_ptr_r[AW-1:0]];
  assign trace_order = order_mem_r[rd_ptr_r[AW-1:0]];
  assign trace_inst  = inst_mem_r[rd_ptr_r[AW-1:0]];

  // Per-lane FIFO slot allocation, drop count and lane-order checking.
  always_comb begin
    n_valid_s    = 3'd0;
    n_drop_s     = 3'd0;
    n_store_s    = '0;
    order_bad_s  = 1'b0;
    gap_s        = 1'b0;
    last_order_s = expected_order_r;
    for (int i = 0; i < COMMIT_W; i++) begin
      wr_en_s[i]  = 1'b0;
      wr_idx_s[i] = '0;
      if (commit_valid[i]) begin
        n_valid_s    = n_valid_s + 3'd1;
        last_order_s = commit_order[i*64 +: 64];
        order_bad_s  = order_bad_s | gap_s |
                       (commit_order[i*64 +: 64] != expected_order_r + 64'(i));
        if (n_store_s < free_s) begin
          wr_en_s[i]  = 1'b1;
          wr_idx_s[i] = AW'(wr_ptr_r + n_store_s);
          n_store_s   = n_store_s + (AW+1)'(1);
        end else begin
          n_drop_s = n_drop_s + 3'd1;
        end
      end else begin
        gap_s = 1'b1;
      end
    end
  end

  // Watchdog idle counter next value; it parks at HANG_CYCLES once reached.
  always_comb begin
    if ((|commit_valid) || rob_empty) begin
      idle_nxt_s = '0;
    end else if (idle_r == HANG_L) begin
      idle_nxt_s = idle_r;
    end else begin
      idle_nxt_s = idle_r + IW'(1);
    end
  end

  // Control state: counters, sticky flags, FIFO pointers, expected order, watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_commit <= '0; cnt_mispred <= '0; cnt_full <= '0; cnt_empty <= '0; cnt_drop <= '0;
      hang <= 1'b0; order_err <= 1'b0;
      wr_ptr_r <= '0; rd_ptr_r <= '0; expected_order_r <= 64'd0; idle_r <= '0;
    end else if (clear) begin
      cnt_commit <= '0; cnt_mispred <= '0; cnt_full <= '0; cnt_empty <= '0; cnt_drop <= '0;
      hang <= 1'b0; order_err <= 1'b0;
      wr_ptr_r <= '0; rd_ptr_r <= '0; expected_order_r <= 64'd0; idle_r <= '0;
    end else begin
      cnt_commit       <= sat_add(cnt_commit, n_valid_s);
      cnt_mispred      <= sat_add(cnt_mispred, 3'(mispredict));
      cnt_full         <= sat_add(cnt_full, 3'(rob_full));
      cnt_empty        <= sat_add(cnt_empty, 3'(rob_empty));
      cnt_drop         <= sat_add(cnt_drop, n_drop_s);
      order_err        <= order_err | order_bad_s;
      wr_ptr_r         <= wr_ptr_r + n_store_s;
      rd_ptr_r         <= rd_ptr_r + (AW+1)'(pop_s);
      expected_order_r <= (|commit_valid) ? last_order_s + 64'd1 : expected_order_r;
      idle_r           <= idle_nxt_s;
      hang             <= hang | (idle_nxt_s == HANG_L);
    end
  end

  // Trace storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_W; i++) begin
      if (wr_en_s[i] && !clear) begin
        pc_mem_r[wr_idx_s[i]]    <= commit_pc[i*32 +: 32];
        order_mem_r[wr_idx_s[i]] <= commit_order[i*64 +: 64];
        inst_mem_r[wr_idx_s[i]]  <= commit_inst[i*32 +: 32];
      end
    end
  end
endmodule
